tcbm_link: RTL and testbench

Drive-side TCBM byte-transfer engine sitting directly downstream of the TPI port emulation. It consumes the host-facing pins (port A data, port B status, port C handshake) and runs the 1551-style DAV/ACK four-phase handshake. It decodes the per-transaction code byte and exposes received command/data bytes and transmit requests to the SD/drive controller through valid/ready streams. A timeout counter keeps the drive side from hanging on a stalled or absent host.

---
 rtl/tcbm_pkg.sv | 26 ++
 rtl/tcbm_link_sync2.sv | 28 ++
 rtl/tcbm_link.sv | 193 +++++++++++++++++++
 tb/tb_tcbm_link.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tcbm_pkg.sv
// tcbm_pkg: shared definitions for the TCBM drive-side link engine.
//   - transaction code bytes sent by the host ahead of each byte transfer
//   - FSM state encoding used by tcbm_link
//   - status encodings presented on port B with transmitted bytes
package tcbm_pkg;

    localparam logic [7:0] CODE_CMD   = 8'h81;  // host sends a command byte
    localparam logic [7:0] CODE_WDATA = 8'h82;  // host sends a data byte
    localparam logic [7:0] CODE_RDATA = 8'h83;  // host reads a byte from the drive

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_EOI     = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StCodeRel,
        StRxWait,
        StRxHold,
        StRxRel,
        StTxWait,
        StTxFetch,
        StTxRel
    } tcbm_state_e;

endpackage

// File: rtl/tcbm_link_sync2.sv
// tcbm_link_sync2: two-flop synchronizer for an idle-high asynchronous strobe.
//   clock   in  system clock
//   _reset  in  async active-low reset; both flops reset to 1 (strobe idle)
//   d_in    in  asynchronous input
//   q_out   out synchronized output
module tcbm_link_sync2 (
    input  logic clock,
    input  logic _reset,
    input  logic d_in,
    output logic q_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/tcbm_link.sv
// tcbm_link: drive-side TCBM byte-transfer engine (1551-style DAV/ACK handshake).
//   clock, _reset          system clock, async active-low reset
//   pa_in/pa_out/pa_oe     port A data from host / drive value / output enable
//   st_out                 status bits on port B
//   dav_in / ack_out       host strobe (active low, async) / drive ack (active low)
//   rx_data/rx_cmd/rx_valid/rx_ready   received byte stream to the controller
//   tx_data/tx_status/tx_valid/tx_ready byte stream from the controller
//   err                    one-cycle pulse on timeout abort
//   busy                   engine not idle
module tcbm_link
    import tcbm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       clock,
    input  logic       _reset,
    input  logic [7:0] pa_in,
    output logic [7:0] pa_out,
    output logic       pa_oe,
    output logic [1:0] st_out,
    input  logic       dav_in,
    output logic       ack_out,
    output logic [7:0] rx_data,
    output logic       rx_cmd,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic [1:0] tx_status,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       err,
    output logic       busy
);

    localparam bit         TimeoutEn   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    logic dav_s;

    tcbm_link_sync2 u_dav_sync (
        .clock  (clock),
        ._reset (_reset),
        .d_in   (dav_in),
        .q_out  (dav_s)
    );

    tcbm_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  pa_q;
    logic [7:0]  code_q, code_d;
    logic [7:0]  pa_out_q, pa_out_d;
    logic        pa_oe_q, pa_oe_d;
    logic [1:0]  st_q, st_d;
    logic        ack_q, ack_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_cmd_q, rx_cmd_d;
    logic        rx_valid_q, rx_valid_d;
    logic        tx_ready_q, tx_ready_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        pa_out_d   = pa_out_q;
        pa_oe_d    = pa_oe_q;
        st_d       = st_q;
        ack_d      = ack_q;
        rx_data_d  = rx_data_q;
        rx_cmd_d   = rx_cmd_q;
        rx_valid_d = rx_valid_q;
        tx_ready_d = tx_ready_q;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle: if (!dav_s) begin
                code_d  = pa_q;
                st_d    = ST_OK;
                ack_d   = 1'b0;
                state_d = StCodeRel;
            end
            StCodeRel: if (dav_s) begin
                ack_d = 1'b1;
                if (code_q == CODE_CMD || code_q == CODE_WDATA) begin
                    rx_cmd_d = (code_q == CODE_CMD);
                    state_d  = StRxWait;
                end else if (code_q == CODE_RDATA) begin
                    state_d = StTxWait;
                end else begin
                    state_d = StIdle;  // unknown code: acknowledged, then dropped
                end
            end
            StRxWait: if (!dav_s) begin
                // ACK stays high until the consumer takes the byte
                rx_data_d  = pa_q;
                rx_valid_d = 1'b1;
                state_d    = StRxHold;
            end
            StRxHold: if (rx_valid_q && rx_ready) begin
                rx_valid_d = 1'b0;
                ack_d      = 1'b0;
                state_d    = StRxRel;
            end
            StRxRel: if (dav_s) begin
                ack_d   = 1'b1;
                state_d = StIdle;
            end
            StTxWait: if (!dav_s) begin
                tx_ready_d = 1'b1;
                state_d    = StTxFetch;
            end
            StTxFetch: if (tx_valid && tx_ready_q) begin
                tx_ready_d = 1'b0;
                pa_out_d   = tx_data;
                st_d       = tx_status;
                pa_oe_d    = 1'b1;
                ack_d      = 1'b0;
                state_d    = StTxRel;
            end
            StTxRel: if (dav_s) begin
                // st_out is left alone so the host can still read it
                ack_d   = 1'b1;
                pa_oe_d = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides any transition taken this cycle
        if (TimeoutEn && state_q != StIdle && cnt_q == TimeoutLast) begin
            ack_d      = 1'b1;
            pa_oe_d    = 1'b0;
            rx_valid_d = 1'b0;
            tx_ready_d = 1'b0;
            err_d      = 1'b1;
            state_d    = StIdle;
        end

        if (state_q == StIdle || state_d != state_q) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            state_q    <= StIdle;
            cnt_q      <= 16'd0;
            pa_q       <= 8'h00;
            code_q     <= 8'h00;
            pa_out_q   <= 8'h00;
            pa_oe_q    <= 1'b0;
            st_q       <= ST_OK;
            ack_q      <= 1'b1;
            rx_data_q  <= 8'h00;
            rx_cmd_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pa_q       <= pa_in;
            code_q     <= code_d;
            pa_out_q   <= pa_out_d;
            pa_oe_q    <= pa_oe_d;
            st_q       <= st_d;
            ack_q      <= ack_d;
            rx_data_q  <= rx_data_d;
            rx_cmd_q   <= rx_cmd_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign pa_out   = pa_out_q;
    assign pa_oe    = pa_oe_q;
    assign st_out   = st_q;
    assign ack_out  = ack_q;
    assign rx_data  = rx_data_q;
    assign rx_cmd   = rx_cmd_q;
    assign rx_valid = rx_valid_q;
    assign tx_ready = tx_ready_q;
    assign err      = err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_tcbm_link.sv
// tb_tcbm_link: directed self-checking bench for tcbm_link (TIMEOUT_CYCLES = 100).
module tb_tcbm_link;

    logic       clock;
    logic       rst_n;
    logic [7:0] pa_in;
    logic [7:0] pa_out;
    logic       pa_oe;
    logic [1:0] st_out;
    logic       dav_in;
    logic       ack_out;
    logic [7:0] rx_data;
    logic       rx_cmd;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic [1:0] tx_status;
    logic       tx_valid;
    logic       tx_ready;
    logic       err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    tcbm_link #(.TIMEOUT_CYCLES(100)) dut (
        .clock     (clock),
        ._reset    (rst_n),
        .pa_in     (pa_in),
        .pa_out    (pa_out),
        .pa_oe     (pa_oe),
        .st_out    (st_out),
        .dav_in    (dav_in),
        .ack_out   (ack_out),
        .rx_data   (rx_data),
        .rx_cmd    (rx_cmd),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_status (tx_status),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .err       (err),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return ack_out;
            1:       return rx_valid;
            2:       return tx_ready;
            3:       return pa_oe;
            default: return busy;
        endcase
    endfunction

    task automatic wait_for(input int which, input logic lvl, input string tag);
        int n = 0;
        while (sig(which) !== lvl && n < 200) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(sig(which)), 32'(lvl));
    endtask

    task automatic send_code(input logic [7:0] code, input string tag);
        pa_in  = code;
        dav_in = 1'b0;
        wait_for(0, 1'b0, {tag, "_ack_lo"});
        dav_in = 1'b1;
        wait_for(0, 1'b1, {tag, "_ack_hi"});
    endtask

    initial begin
        logic stuck;

        rst_n     = 1'b0;
        pa_in     = 8'h00;
        dav_in    = 1'b1;
        rx_ready  = 1'b0;
        tx_data   = 8'h00;
        tx_status = 2'b00;
        tx_valid  = 1'b0;
        tick();
        tick();
        check_eq("rst_pa_out", 32'(pa_out), 32'h00);
        check_eq("rst_pa_oe", 32'(pa_oe), 32'h0);
        check_eq("rst_st_out", 32'(st_out), 32'h0);
        check_eq("rst_ack", 32'(ack_out), 32'h1);
        check_eq("rst_rx_valid", 32'(rx_valid), 32'h0);
        check_eq("rst_tx_ready", 32'(tx_ready), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        tick();
        tick();

        // Command byte 0x4C with consumer always ready
        rx_ready = 1'b1;
        send_code(8'h81, "t1_code");
        pa_in  = 8'h4C;
        dav_in = 1'b0;
        tick();
        tick();
        check_eq("t1_rx_valid_e2", 32'(rx_valid), 32'h0);
        tick();
        check_eq("t1_rx_valid_e3", 32'(rx_valid), 32'h1);
        check_eq("t1_rx_data", 32'(rx_data), 32'h4C);
        check_eq("t1_rx_cmd", 32'(rx_cmd), 32'h1);
        check_eq("t1_ack_hold", 32'(ack_out), 32'h1);
        tick();
        check_eq("t1_rx_valid_drop", 32'(rx_valid), 32'h0);
        check_eq("t1_ack_lo", 32'(ack_out), 32'h0);
        dav_in = 1'b1;
        wait_for(0, 1'b1, "t1_ack_hi");
        check_eq("t1_busy_end", 32'(busy), 32'h0);
        tick();

        // Data byte 0xA5 with backpressure for 20 cycles
        rx_ready = 1'b0;
        send_code(8'h82, "t2_code");
        pa_in  = 8'hA5;
        dav_in = 1'b0;
        wait_for(1, 1'b1, "t2_rx_valid");
        check_eq("t2_rx_data", 32'(rx_data), 32'hA5);
        check_eq("t2_rx_cmd", 32'(rx_cmd), 32'h0);
        stuck = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack_out !== 1'b1 || rx_valid !== 1'b1) stuck = 1'b0;
        end
        check_eq("t2_backpressure", 32'(stuck), 32'h1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check_eq("t2_rx_valid_drop", 32'(rx_valid), 32'h0);
        check_eq("t2_ack_lo", 32'(ack_out), 32'h0);
        dav_in = 1'b1;
        wait_for(0, 1'b1, "t2_ack_hi");
        tick();

        // Host read: 0x31 with EOI
        tx_data   = 8'h31;
        tx_status = 2'b11;
        tx_valid  = 1'b1;
        send_code(8'h83, "t3_code");
        dav_in = 1'b0;
        tick();
        tick();
        check_eq("t3_tx_ready_e2", 32'(tx_ready), 32'h0);
        tick();
        check_eq("t3_tx_ready_e3", 32'(tx_ready), 32'h1);
        check_eq("t3_pa_oe_pre", 32'(pa_oe), 32'h0);
        tick();
        check_eq("t3_tx_ready_drop", 32'(tx_ready), 32'h0);
        check_eq("t3_pa_oe", 32'(pa_oe), 32'h1);
        check_eq("t3_ack_lo", 32'(ack_out), 32'h0);
        check_eq("t3_pa_out", 32'(pa_out), 32'h31);
        check_eq("t3_st_out", 32'(st_out), 32'h3);
        tx_valid = 1'b0;
        dav_in   = 1'b1;
        wait_for(0, 1'b1, "t3_ack_hi");
        check_eq("t3_pa_oe_rel", 32'(pa_oe), 32'h0);
        check_eq("t3_st_hold", 32'(st_out), 32'h3);
        tick();
        tick();

        // Unknown code 0x90: acknowledged then ignored; clears status
        check_eq("t4_st_before", 32'(st_out), 32'h3);
        pa_in  = 8'h90;
        dav_in = 1'b0;
        wait_for(0, 1'b0, "t4_ack_lo");
        check_eq("t4_st_cleared", 32'(st_out), 32'h0);
        dav_in = 1'b1;
        wait_for(0, 1'b1, "t4_ack_hi");
        check_eq("t4_busy", 32'(busy), 32'h0);
        stuck = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rx_valid !== 1'b0 || tx_ready !== 1'b0 || busy !== 1'b0) stuck = 1'b1;
        end
        check_eq("t4_no_stream", 32'(stuck), 32'h0);

        // Timeout: code 0x81, then DAV held high in RX_WAIT
        send_code(8'h81, "t5_code");
        stuck = 1'b0;
        for (int i = 0; i < 99; i++) begin
            tick();
            if (err !== 1'b0) stuck = 1'b1;
        end
        check_eq("t5_no_early_err", 32'(stuck), 32'h0);
        check_eq("t5_busy_before", 32'(busy), 32'h1);
        tick();
        check_eq("t5_err", 32'(err), 32'h1);
        check_eq("t5_busy_after", 32'(busy), 32'h0);
        check_eq("t5_ack", 32'(ack_out), 32'h1);
        tick();
        check_eq("t5_err_pulse", 32'(err), 32'h0);
        tick();

        // Async reset while driving port A in TX_REL
        tx_data   = 8'h5A;
        tx_status = 2'b00;
        tx_valid  = 1'b1;
        send_code(8'h83, "t6_code");
        dav_in = 1'b0;
        wait_for(3, 1'b1, "t6_pa_oe");
        check_eq("t6_ack_lo", 32'(ack_out), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_pa_oe", 32'(pa_oe), 32'h0);
        check_eq("t6_rst_ack", 32'(ack_out), 32'h1);
        check_eq("t6_rst_busy", 32'(busy), 32'h0);
        tx_valid = 1'b0;
        dav_in   = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        rx_ready = 1'b1;
        send_code(8'h81, "t6_code2");
        pa_in  = 8'h3C;
        dav_in = 1'b0;
        wait_for(1, 1'b1, "t6_rx_valid");
        check_eq("t6_rx_data", 32'(rx_data), 32'h3C);
        check_eq("t6_rx_cmd", 32'(rx_cmd), 32'h1);
        wait_for(0, 1'b0, "t6_ack_lo2");
        dav_in = 1'b1;
        wait_for(0, 1'b1, "t6_ack_hi2");
        check_eq("t6_busy_end", 32'(busy), 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
